// File: rtl/tc77_responder_if.sv
// tc77_responder_if: the 3-wire nCS/SCK/SIO temperature bus between the tempsense
// master and the TC77 emulator. SIO is split into pad input, output and enable;
// the top level merges them into one tristate pin.
interface tc77_responder_if;
   logic nCS;
   logic SCK;
   logic SIO_I;
   logic SIO_O;
   logic SIO_OE;

   modport master (
      output nCS,
      output SCK,
      output SIO_I,
      input  SIO_O,
      input  SIO_OE
   );

   modport slave (
      input  nCS,
      input  SCK,
      input  SIO_I,
      output SIO_O,
      output SIO_OE
   );
endinterface

// File: rtl/tc77_responder.sv
// tc77_responder: synthesizable TC77 emulator (sensor end of the nCS/SCK/SIO bus).
// Keeps a 13-bit temperature register refreshed from TEMP_IN every CONV_CYCLES
// MCLK cycles while awake, shifts a snapshotted 16-bit frame out MSB-first on SCK
// falls, then takes a 16-bit config word on SCK rises (FFFF = shutdown, 0000 = wake).
// Optional feature macro: TC77_XACT_CNT_EN adds XACT_CNT, a saturating count of
// completed 16-bit read phases.
module tc77_responder #(
   parameter logic [23:0] CONV_CYCLES = 24'd1000,
   parameter logic [15:0] MFR_ID      = 16'h5400
) (
   input  logic               MCLK,
   input  logic               nRESET,
   input  logic signed [12:0] TEMP_IN,
   tc77_responder_if.slave    bus,
   output logic               SHDN,
   output logic               CONV_DONE
`ifdef TC77_XACT_CNT_EN
   ,
   output logic [15:0]        XACT_CNT
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic               ncs_p0, ncs_p1, ncs_p2;
   logic               sck_p0, sck_p1, sck_p2;
   logic               sio_p0, sio_p1;
   logic               ncs_fall, ncs_rise, sck_fall, sck_rise;

   logic [1:0]         state;
   logic [3:0]         bitcnt;
   logic [14:0]        tx_sr;
   logic [14:0]        cfg_sr;
   logic [15:0]        cfg_word;
   logic [15:0]        frame_word;
   logic               cfg_last, cfg_wake, cfg_sleep;

   logic [23:0]        conv_cnt;
   logic signed [12:0] temp_reg;
   logic               sio_o_q, sio_oe_q, shdn_q, conv_done_q;

   // Bus control lines: two-flop synchronizer plus a history flop for edge detection.
   // nCS resets to its idle-high level so leaving reset never looks like a select.
   always_ff @(posedge MCLK) begin
      if (!nRESET) begin
         ncs_p0 <= 1'b1;
         ncs_p1 <= 1'b1;
         ncs_p2 <= 1'b1;
         sck_p0 <= 1'b0;
         sck_p1 <= 1'b0;
         sck_p2 <= 1'b0;
      end else begin
         ncs_p0 <= bus.nCS;
         ncs_p1 <= ncs_p0;
         ncs_p2 <= ncs_p1;
         sck_p0 <= bus.SCK;
         sck_p1 <= sck_p0;
         sck_p2 <= sck_p1;
      end
   end

   // SIO data synchronizer, aligned with the SCK chain so a rise sees settled data
   always_ff @(posedge MCLK) begin
      sio_p0 <= bus.SIO_I;
      sio_p1 <= sio_p0;
   end

   // Edge decode, frame selection and config decode at the last write bit
   always_comb begin
      ncs_fall   = ncs_p2 & ~ncs_p1;
      ncs_rise   = ~ncs_p2 & ncs_p1;
      sck_fall   = ~ncs_p1 & sck_p2 & ~sck_p1;
      sck_rise   = ~ncs_p1 & ~sck_p2 & sck_p1;
      frame_word = shdn_q ? MFR_ID : {temp_reg, conv_done_q, 2'b00};
      cfg_word   = {cfg_sr, sio_p1};
      cfg_last   = (state == ST_WRITE) && sck_rise && (bitcnt == 4'd15);
      cfg_wake   = cfg_last && (cfg_word == 16'h0000);
      cfg_sleep  = cfg_last && (cfg_word == 16'hFFFF);
   end

   // Bus transaction FSM: snapshot and shift out on SCK falls, then collect config on rises
   always_ff @(posedge MCLK) begin
      if (!nRESET) begin
         state    <= ST_IDLE;
         bitcnt   <= 4'd0;
         sio_o_q  <= 1'b0;
         sio_oe_q <= 1'b0;
      end else if (ncs_rise) begin
         state    <= ST_IDLE;
         sio_oe_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ncs_fall) begin
                  tx_sr    <= frame_word[14:0];
                  sio_o_q  <= frame_word[15];
                  sio_oe_q <= 1'b1;
                  bitcnt   <= 4'd0;
                  state    <= ST_READ;
               end
            end
            ST_READ: begin
               if (sck_fall) begin
                  if (bitcnt == 4'd15) begin
                     sio_oe_q <= 1'b0;
                     bitcnt   <= 4'd0;
                     state    <= ST_WRITE;
                  end else begin
                     bitcnt  <= bitcnt + 4'd1;
                     sio_o_q <= tx_sr[14];
                     tx_sr   <= {tx_sr[13:0], 1'b0};
                  end
               end
            end
            ST_WRITE: begin
               if (sck_rise) begin
                  cfg_sr <= cfg_word[14:0];
                  if (bitcnt == 4'd15) begin
                     bitcnt <= 4'd0;
                     state  <= ST_DONE;
                  end else begin
                     bitcnt <= bitcnt + 4'd1;
                  end
               end
            end
            default: begin
               sio_oe_q <= 1'b0;
            end
         endcase
      end
   end

   // Conversion timing and shutdown/wake handling; wake overrides a same-cycle conversion flag
   always_ff @(posedge MCLK) begin
      if (!nRESET) begin
         conv_cnt    <= 24'd0;
         temp_reg    <= 13'sd0;
         conv_done_q <= 1'b0;
         shdn_q      <= 1'b0;
      end else begin
         if (!shdn_q) begin
            if (conv_cnt == CONV_CYCLES - 24'd1) begin
               temp_reg    <= TEMP_IN;
               conv_done_q <= 1'b1;
               conv_cnt    <= 24'd0;
            end else begin
               conv_cnt <= conv_cnt + 24'd1;
            end
         end
         if (cfg_wake) begin
            shdn_q      <= 1'b0;
            conv_done_q <= 1'b0;
            conv_cnt    <= 24'd0;
         end else if (cfg_sleep) begin
            shdn_q <= 1'b1;
         end
      end
   end

`ifdef TC77_XACT_CNT_EN
   logic        read_done;
   logic [15:0] xact_cnt;

   assign read_done = (state == ST_READ) && sck_fall && (bitcnt == 4'd15) && !ncs_rise;

   // Count completed 16-bit read phases, holding at full scale
   always_ff @(posedge MCLK) begin
      if (!nRESET) begin
         xact_cnt <= 16'd0;
      end else if (read_done && (xact_cnt != 16'hFFFF)) begin
         xact_cnt <= xact_cnt + 16'd1;
      end
   end

   assign XACT_CNT = xact_cnt;
`endif

   assign bus.SIO_O  = sio_o_q;
   assign bus.SIO_OE = sio_oe_q;
   assign SHDN       = shdn_q;
   assign CONV_DONE  = conv_done_q;

endmodule
